tunnel_score_keeper: RTL

Parametrised successor to the tunnel game's crash and score logic. It watches `N_SQ` obstacle squares as each reaches the screen plane (depth 0) and classifies each arrival as a pass-through (hit) or a collision (miss). It keeps a `DIGITS`-digit BCD score and a lives counter, and drives the game-over (`crashed`) and `go` controls consumed by the square and cruiser updaters. Optionally it drives the autopilot arrow vector from the nearest square.

---
 rtl/tunnel_score_keeper.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/tunnel_score_keeper.sv
// Crash and score keeper for the tunnel game: classifies square arrivals at depth 0,
// keeps a saturating BCD score and a lives counter. Optional autopilot: TUNNEL_AUTOPILOT_EN.
module tunnel_score_keeper #(
    parameter int N_SQ   = 4,
    parameter int CW     = 9,
    parameter int DW     = 6,
    parameter int DIGITS = 3,
    parameter int LIVES  = 3,
    parameter int X_LO   = 0,
    parameter int X_HI   = 127,
    parameter int Y_LO   = -32,
    parameter int Y_HI   = 93
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    input  logic [N_SQ*CW-1:0]    xc,
    input  logic [N_SQ*CW-1:0]    yc,
    input  logic [N_SQ*DW-1:0]    d,
    output logic [DIGITS*4-1:0]   score,
    output logic [3:0]            lives,
    output logic                  crashed,
    output logic                  go,
    output logic                  hit_pulse,
    output logic                  miss_pulse,
    output logic [3:0]            arrow
);

    localparam logic signed [CW-1:0] X_LO_C  = CW'(X_LO);
    localparam logic signed [CW-1:0] X_HI_C  = CW'(X_HI);
    localparam logic signed [CW-1:0] Y_LO_C  = CW'(Y_LO);
    localparam logic signed [CW-1:0] Y_HI_C  = CW'(Y_HI);
    localparam logic [3:0]           LIVES_C = 4'(LIVES);

    logic [N_SQ-1:0]     d_nz;
    logic [N_SQ-1:0]     in_win;
    logic [N_SQ-1:0]     arrival;
    logic [N_SQ-1:0]     armed_q;
    logic [N_SQ-1:0]     arr_q;
    logic [N_SQ-1:0]     in_q;
    logic [N_SQ-1:0]     hit_vec;
    logic                miss_any;
    logic [3:0]          hit_cnt;
    logic [DIGITS*4-1:0] score_q;
    logic [DIGITS*4-1:0] score_sum;
    logic [DIGITS*4-1:0] score_next;
    logic [3:0]          lives_q;
    logic [4:0]          dsum;
    logic                carry;

    for (genvar g = 0; g < N_SQ; g++) begin : g_slot
        logic signed [CW-1:0] xs;
        logic signed [CW-1:0] ys;
        assign xs          = xc[g*CW +: CW];
        assign ys          = yc[g*CW +: CW];
        assign d_nz[g]     = |d[g*DW +: DW];
        assign in_win[g]   = (xs >= X_LO_C) && (xs <= X_HI_C) &&
                             (ys >= Y_LO_C) && (ys <= Y_HI_C);
    end

    // A slot fires once per visit to depth 0; leaving 0 re-arms it.
    assign arrival = armed_q & ~d_nz;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q <= '1;
        end else if (restart) begin
            armed_q <= '1;
        end else begin
            armed_q <= (armed_q & ~arrival) | d_nz;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arr_q <= '0;
            in_q  <= '0;
        end else if (restart) begin
            arr_q <= '0;
            in_q  <= '0;
        end else begin
            arr_q <= arrival;
            in_q  <= in_win;
        end
    end

    assign hit_vec  = arr_q & in_q;
    assign miss_any = |(arr_q & ~in_q);

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < N_SQ; i++) begin
            hit_cnt = hit_cnt + 4'(hit_vec[i]);
        end
    end

    // Ripple BCD add of the hit count; carry out of the top digit means the
    // sum passed all 9s, so the score pins there instead of wrapping.
    always_comb begin
        score_sum = score_q;
        carry     = 1'b0;
        dsum      = '0;
        for (int k = 0; k < DIGITS; k++) begin
            dsum = {1'b0, score_q[k*4 +: 4]} + {4'b0, carry};
            if (k == 0) begin
                dsum = dsum + {1'b0, hit_cnt};
            end
            if (dsum > 5'd9) begin
                score_sum[k*4 +: 4] = 4'(dsum - 5'd10);
                carry               = 1'b1;
            end else begin
                score_sum[k*4 +: 4] = dsum[3:0];
                carry               = 1'b0;
            end
        end
        score_next = carry ? {DIGITS{4'h9}} : score_sum;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score_q    <= '0;
            lives_q    <= LIVES_C;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else if (restart) begin
            score_q    <= '0;
            lives_q    <= LIVES_C;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            // go implies lives_q is nonzero, so the decrement cannot underflow.
            if (go) begin
                if (|hit_vec) begin
                    score_q   <= score_next;
                    hit_pulse <= 1'b1;
                end
                if (miss_any) begin
                    lives_q    <= lives_q - 4'd1;
                    miss_pulse <= 1'b1;
                end
            end
        end
    end

    assign score   = score_q;
    assign lives   = lives_q;
    assign crashed = (lives_q == 4'd0);
    assign go      = ~crashed;

`ifdef TUNNEL_AUTOPILOT_EN
    localparam logic signed [CW-1:0] T16 = CW'(16);
    localparam logic signed [CW-1:0] T48 = CW'(48);
    localparam logic signed [CW-1:0] T80 = CW'(80);

    logic                 sel_valid;
    logic [DW-1:0]        sel_d;
    logic signed [CW-1:0] sel_x;
    logic signed [CW-1:0] sel_y;
    logic [3:0]           arrow_next;
    logic [3:0]           arrow_q;

    // Strict less-than keeps the lowest index on equal depths.
    always_comb begin
        sel_valid = 1'b0;
        sel_d     = '1;
        sel_x     = '0;
        sel_y     = '0;
        for (int i = 0; i < N_SQ; i++) begin
            if (armed_q[i] && d_nz[i] && (!sel_valid || d[i*DW +: DW] < sel_d)) begin
                sel_valid = 1'b1;
                sel_d     = d[i*DW +: DW];
                sel_x     = xc[i*CW +: CW];
                sel_y     = yc[i*CW +: CW];
            end
        end
        arrow_next = sel_valid ? {sel_x > T80, sel_x < T48, sel_y >= T48, sel_y < T16} : 4'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arrow_q <= 4'b0;
        end else begin
            arrow_q <= arrow_next;
        end
    end

    assign arrow = arrow_q;
`else
    assign arrow = 4'b0;
`endif

endmodule
